instr_encoder_loader: RTL

- Sequential instruction encoder and loader for the single-cycle MIPS core; the inverse of the opcode-to-control decode path.
- Accepts decoded instruction fields over a valid/ready stream.
- Packs them into 32-bit MIPS words for the same opcode subset the control unit decodes (R-type, addi, beq, j, lw, sw).
- Writes the words sequentially into instruction memory, so benches and boot logic can load programs without hand-assembled hex.

---
 rtl/instr_encoder_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Sequential MIPS instruction encoder and loader.
// Takes decoded instruction fields over a valid/ready stream, packs each item
// into a 32-bit MIPS word (R-type, addi, beq, j, lw, sw) and writes the words
// to consecutive instruction-memory addresses starting at BASE_ADDR.
module instr_encoder_loader #(
   parameter int          DEPTH     = 64,
   parameter int          CNT_W     = 7,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_kind,
   input  logic [4:0]       in_rs,
   input  logic [4:0]       in_rt,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_shamt,
   input  logic [5:0]       in_funct,
   input  logic [15:0]      in_imm,
   input  logic [25:0]      in_target,
   input  logic             in_last,
   output logic             imem_we,
   output logic [31:0]      imem_addr,
   output logic [31:0]      imem_wdata,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             full,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   state_t           state_q;
   logic [CNT_W-1:0] count_q;
   logic             imemWe_q;
   logic [31:0]      imemAddr_q;
   logic [31:0]      imemWdata_q;
   logic             done_q;
   logic             full_q;
   logic             err_q;

   logic [31:0]      wdata_d;
   logic [31:0]      addr_d;
   logic [CNT_W-1:0] count_d;
   logic             kindLegal;
   logic             accept;
   logic             reachDepth;

   // Encode the incoming fields into a MIPS word; kinds 6 and 7 flag illegal.
   always_comb begin
      wdata_d   = 32'h0000_0000;
      kindLegal = 1'b1;
      case (in_kind)
         3'd0:    wdata_d = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
         3'd1:    wdata_d = {6'b001000, in_rs, in_rt, in_imm};
         3'd2:    wdata_d = {6'b000100, in_rs, in_rt, in_imm};
         3'd3:    wdata_d = {6'b000010, in_target};
         3'd4:    wdata_d = {6'b100011, in_rs, in_rt, in_imm};
         3'd5:    wdata_d = {6'b101011, in_rs, in_rt, in_imm};
         default: kindLegal = 1'b0;
      endcase
   end

   // Handshake, write address and count arithmetic for the item being offered.
   always_comb begin
      in_ready   = (state_q == LOAD) && (count_q < DEPTH_C);
      accept     = in_valid && in_ready;
      addr_d     = BASE_ADDR + (32'(count_q) << 2);
      count_d    = count_q + CNT_W'(1);
      reachDepth = (count_d == DEPTH_C);
   end

   // Session FSM; every output is registered here so writes land one cycle after accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         imemWe_q    <= 1'b0;
         imemAddr_q  <= BASE_ADDR;
         imemWdata_q <= 32'h0000_0000;
         done_q      <= 1'b0;
         full_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         imemWe_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= LOAD;
                  count_q <= '0;
                  full_q  <= 1'b0;
                  err_q   <= 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (kindLegal) begin
                     imemWe_q    <= 1'b1;
                     imemAddr_q  <= addr_d;
                     imemWdata_q <= wdata_d;
                     count_q     <= count_d;
                     if (in_last || reachDepth) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end
                     if (reachDepth && !in_last) begin
                        full_q <= 1'b1;
                     end
                  end else begin
                     err_q <= 1'b1;
                     if (in_last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign imem_we    = imemWe_q;
   assign imem_addr  = imemAddr_q;
   assign imem_wdata = imemWdata_q;
   assign count      = count_q;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign full       = full_q;
   assign err        = err_q;

endmodule
